// File: rtl/zap_wb_pkg.sv
// Shared definitions for the Wishbone RAM responder: cycle type encodings,
// responder FSM states and the cycle-type normalisation helper.
package zap_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  // Any cycle type other than incrementing burst or end-of-burst is treated
  // as a classic single access.
  function automatic logic [2:0] cti_norm(input logic [2:0] cti);
    case (cti)
      CTI_INCR, CTI_EOB: return cti;
      default:           return CTI_CLASSIC;
    endcase
  endfunction

endpackage

// File: rtl/zap_be_sp_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered
// read. Each byte lane is its own narrow array so that block RAM inference
// sees a plain write-enable per lane.
module zap_be_sp_ram #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Lane write when enabled; read returns the pre-write contents.
    always_ff @(posedge i_clk) begin
      if (i_we && i_be[gi]) begin
        r_mem[i_addr] <= i_wdata[gi*8 +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end

    assign o_rdata[gi*8 +: 8] = r_rdata;
  end

endmodule

// File: rtl/zap_wb_ram_responder.sv
// Wishbone slave in front of a byte-enable RAM. Supports classic cycles and
// incrementing bursts, a programmable number of wait states before the first
// beat, error responses outside the mapped window, and cycle abort.
module zap_wb_ram_responder
  import zap_wb_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_wen,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_wb_cti,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WS_LOAD = WS_M1[3:0];

  wb_state_t     r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_adr;
  logic          r_wen;
  logic [3:0]    r_sel;
  logic [31:0]   r_dat;
  logic [2:0]    r_cti;
  logic          r_oor;   // first beat fell outside the window
  logic          r_ack;
  logic          r_err;

  logic          w_req;
  logic          w_in_range;
  logic [AW-1:0] w_adr_in;
  logic [AW-1:0] w_adr_next;
  logic [2:0]    w_cti_in;
  logic          w_burst_next;
  logic          w_ram_we;
  logic [3:0]    w_ram_be;
  logic [AW-1:0] w_ram_addr;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;
  logic          w_unused_adr_lsb;

  assign w_req        = i_wb_cyc && i_wb_stb;
  // BASE_ADDR is aligned to the window size, so only the upper bits decide.
  assign w_in_range   = (i_wb_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_adr_in     = i_wb_adr[AW+1:2];
  assign w_adr_next   = r_adr + AW'(1);   // wraps modulo DEPTH inside a burst
  assign w_cti_in     = cti_norm(i_wb_cti);
  assign w_burst_next = (r_state == RESP) && (r_cti == CTI_INCR) && w_req;
  assign w_unused_adr_lsb = ^i_wb_adr[1:0];

  // RAM port steering: the port is driven for the beat whose ack is being
  // registered on this edge, so write commit and read data line up with ack.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_be    = i_wb_sel;
    w_ram_addr  = w_adr_in;
    w_ram_wdata = i_wb_dat;
    case (r_state)
      IDLE: begin
        w_ram_we = w_req && i_wb_wen && w_in_range && (WAIT_STATES == 0);
      end
      WAIT: begin
        w_ram_addr  = r_adr;
        w_ram_be    = r_sel;
        w_ram_wdata = r_dat;
        w_ram_we    = (r_cnt == '0) && i_wb_cyc && r_wen && !r_oor;
      end
      RESP: begin
        w_ram_addr = w_adr_next;
        w_ram_we   = w_burst_next && i_wb_wen;
      end
      default: begin
        w_ram_we = 1'b0;
      end
    endcase
  end

  // Responder FSM with wait-state counter and registered ack/err.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wen   <= 1'b0;
      r_sel   <= '0;
      r_dat   <= '0;
      r_cti   <= CTI_CLASSIC;
      r_oor   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_adr <= w_adr_in;
            r_wen <= i_wb_wen;
            r_sel <= i_wb_sel;
            r_dat <= i_wb_dat;
            r_oor <= !w_in_range;
            // An errored first beat never continues as a burst.
            r_cti <= w_in_range ? w_cti_in : CTI_CLASSIC;
            if (WAIT_STATES == 0) begin
              r_state <= RESP;
              r_ack   <= w_in_range;
              r_err   <= !w_in_range;
            end else begin
              r_cnt   <= WS_LOAD;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!i_wb_cyc) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= RESP;
            r_ack   <= !r_oor;
            r_err   <= r_oor;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (!i_wb_cyc || (r_cti != CTI_INCR)) begin
            r_state <= IDLE;
          end else if (i_wb_stb) begin
            r_adr <= w_adr_next;
            r_wen <= i_wb_wen;
            r_sel <= i_wb_sel;
            r_dat <= i_wb_dat;
            r_cti <= w_cti_in;
            r_ack <= 1'b1;
          end
          // stb low inside a burst: stay here, ack low, address held
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  zap_be_sp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign o_wb_ack = r_ack;
  assign o_wb_err = r_err;
  assign o_wb_dat = r_ack ? w_ram_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_zap_wb_ram_responder.sv
// Directed bench: four responders with 0, 2, 3 and 5 wait states share one
// clock and reset; each scenario task drives one of them and checks inline.
module tb_zap_wb_ram_responder;
  import zap_wb_pkg::*;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  logic        clk;
  logic        reset_n;
  logic        cyc  [4];
  logic        stb  [4];
  logic        wen  [4];
  logic [3:0]  sel  [4];
  logic [31:0] adr  [4];
  logic [31:0] wdat [4];
  logic [2:0]  cti  [4];
  logic [31:0] rdat [4];
  logic        ack  [4];
  logic        err  [4];

  int checks   = 0;
  int failures = 0;

  int          b_ack_n [8];
  logic [31:0] b_rd    [8];
  logic [31:0] b_wd    [8];
  int          b_nack;
  int          b_nerr;
  int          b_post;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    zap_wb_ram_responder #(
      .DEPTH       (1024),
      .WAIT_STATES (ws_of(gi)),
      .BASE_ADDR   (32'h0000_0000)
    ) u_dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_wb_cyc  (cyc[gi]),
      .i_wb_stb  (stb[gi]),
      .i_wb_wen  (wen[gi]),
      .i_wb_sel  (sel[gi]),
      .i_wb_adr  (adr[gi]),
      .i_wb_dat  (wdat[gi]),
      .i_wb_cti  (cti[gi]),
      .o_wb_dat  (rdat[gi]),
      .o_wb_ack  (ack[gi]),
      .o_wb_err  (err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single classic access; lat = n when the response is seen after edge k+n.
  task automatic wb_single(input int d, input logic we, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] dw,
                           output int lat, output logic got_ack,
                           output logic got_err, output logic [31:0] dr);
    lat = -1; got_ack = 1'b0; got_err = 1'b0; dr = '0;
    cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = we; sel[d] = s;
    adr[d] = a; wdat[d] = dw; cti[d] = CTI_CLASSIC;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = n; got_ack = ack[d]; got_err = err[d]; dr = rdat[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    $display("txn dut%0d %s adr=%08h sel=%b wdat=%08h lat=%0d ack=%b err=%b rdat=%08h",
             d, we ? "WR" : "RD", a, s, dw, lat, got_ack, got_err, dr);
  endtask

  // Incrementing burst of nb beats; optional one-cycle stb drop before beat stall_at.
  task automatic wb_burst(input int d, input logic we, input logic [31:0] a0,
                          input int nb, input int stall_at);
    int beat = 0;
    b_nack = 0; b_nerr = 0; b_post = 0;
    for (int i = 0; i < 8; i++) begin b_ack_n[i] = -1; b_rd[i] = '0; end
    cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = we; sel[d] = 4'hF;
    adr[d] = a0; wdat[d] = b_wd[0]; cti[d] = (nb == 1) ? CTI_EOB : CTI_INCR;
    for (int n = 0; n < 40 && beat < nb; n++) begin
      @(posedge clk); @(negedge clk);
      if (err[d]) b_nerr++;
      if (ack[d]) begin
        b_ack_n[beat] = n; b_rd[beat] = rdat[d]; b_nack++; beat++;
        if (beat < nb) begin
          adr[d]  = a0 + 32'(4 * beat);
          wdat[d] = b_wd[beat];
          cti[d]  = (beat == nb - 1) ? CTI_EOB : CTI_INCR;
          if (beat == stall_at) stb[d] = 1'b0;
        end
      end else if (!stb[d]) begin
        stb[d] = 1'b1;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0; cti[d] = CTI_CLASSIC;
    @(posedge clk); @(negedge clk);
    if (ack[d] || err[d]) b_post++;
    $display("txn dut%0d burst %s a0=%08h beats=%0d acked=%0d errs=%0d",
             d, we ? "WR" : "RD", a0, nb, b_nack, b_nerr);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ack[d] !== 1'b0) begin failures++; $display("FAIL reset_ack dut%0d got=%b exp=0", d, ack[d]); end
      checks++;
      if (err[d] !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got=%b exp=0", d, err[d]); end
      checks++;
      if (rdat[d] !== 32'h0) begin failures++; $display("FAIL reset_dat dut%0d got=%08h exp=0", d, rdat[d]); end
    end
  endtask

  task automatic test_classic();
    int lat; logic ga, ge; logic [31:0] dr;
    wb_single(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat, ga, ge, dr);
    checks++;
    if (lat !== 0 || ga !== 1'b1 || ge !== 1'b0) begin
      failures++; $display("FAIL classic_wr lat=%0d ack=%b err=%b exp lat=0 ack=1 err=0", lat, ga, ge);
    end
    wb_single(0, 1'b0, 32'h10, 4'hF, 32'h0, lat, ga, ge, dr);
    checks++;
    if (lat !== 0 || ga !== 1'b1) begin
      failures++; $display("FAIL classic_rd_lat lat=%0d ack=%b exp lat=0 ack=1", lat, ga);
    end
    checks++;
    if (dr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL classic_rd_dat got=%08h exp=deadbeef", dr); end
  endtask

  task automatic test_wait_states();
    int lat; logic ga, ge; logic [31:0] dr; logic [5:0] ackv; logic anyerr;
    wb_single(2, 1'b1, 32'h10, 4'hF, 32'h0303_0303, lat, ga, ge, dr);
    checks++;
    if (lat !== 3 || ga !== 1'b1) begin failures++; $display("FAIL ws3_wr_lat lat=%0d ack=%b exp lat=3 ack=1", lat, ga); end
    ackv = '0; anyerr = 1'b0; dr = '0;
    cyc[2] = 1'b1; stb[2] = 1'b1; wen[2] = 1'b0; sel[2] = 4'hF; adr[2] = 32'h10; cti[2] = CTI_CLASSIC;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); @(negedge clk);
      ackv[n] = ack[2];
      if (err[2]) anyerr = 1'b1;
      if (n == 3) dr = rdat[2];
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    checks++;
    if (ackv !== 6'b001000) begin failures++; $display("FAIL ws3_held_ack_pattern got=%b exp=001000", ackv); end
    checks++;
    if (dr !== 32'h0303_0303 || anyerr !== 1'b0) begin
      failures++; $display("FAIL ws3_held_rd_dat got=%08h err=%b exp=03030303 err=0", dr, anyerr);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic ga, ge; logic [31:0] dr;
    wb_single(0, 1'b1, 32'h40, 4'hF, 32'hFFFF_FFFF, lat, ga, ge, dr);
    wb_single(0, 1'b1, 32'h40, 4'b0101, 32'h1122_3344, lat, ga, ge, dr);
    wb_single(0, 1'b0, 32'h42, 4'b0000, 32'h0, lat, ga, ge, dr);
    checks++;
    if (dr !== 32'hFF22_FF44 || ga !== 1'b1) begin
      failures++; $display("FAIL byte_lanes got=%08h ack=%b exp=ff22ff44 ack=1", dr, ga);
    end
  endtask

  task automatic test_burst_wrap();
    int lat; logic ga, ge; logic [31:0] dr; logic [31:0] ew [4];
    ew[0] = 32'hA000_03FE; ew[1] = 32'hA000_03FF; ew[2] = 32'hA000_0000; ew[3] = 32'hA000_0001;
    wb_single(1, 1'b1, 32'hFF8, 4'hF, ew[0], lat, ga, ge, dr);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL ws2_wr_lat got=%0d exp=2", lat); end
    wb_single(1, 1'b1, 32'hFFC, 4'hF, ew[1], lat, ga, ge, dr);
    wb_single(1, 1'b1, 32'h000, 4'hF, ew[2], lat, ga, ge, dr);
    wb_single(1, 1'b1, 32'h004, 4'hF, ew[3], lat, ga, ge, dr);
    wb_burst(1, 1'b0, 32'hFF8, 4, -1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b_ack_n[i] !== 2 + i) begin
        failures++; $display("FAIL burst_wrap_ack_cycle beat%0d got=%0d exp=%0d", i, b_ack_n[i], 2 + i);
      end
      checks++;
      if (b_rd[i] !== ew[i]) begin
        failures++; $display("FAIL burst_wrap_dat beat%0d got=%08h exp=%08h", i, b_rd[i], ew[i]);
      end
    end
    checks++;
    if (b_nerr !== 0 || b_post !== 0) begin
      failures++; $display("FAIL burst_wrap_err_post errs=%0d post=%0d exp 0 0", b_nerr, b_post);
    end
  endtask

  task automatic test_burst_stall();
    int ea [3];
    b_wd[0] = 32'hB0B0_0000; b_wd[1] = 32'hB1B1_1111; b_wd[2] = 32'hB2B2_2222;
    wb_burst(0, 1'b1, 32'h80, 3, 1);
    ea[0] = 0; ea[1] = 2; ea[2] = 3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b_ack_n[i] !== ea[i]) begin
        failures++; $display("FAIL stall_wr_ack_cycle beat%0d got=%0d exp=%0d", i, b_ack_n[i], ea[i]);
      end
    end
    wb_burst(0, 1'b0, 32'h80, 3, 2);
    ea[0] = 0; ea[1] = 1; ea[2] = 3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b_ack_n[i] !== ea[i] || b_rd[i] !== b_wd[i]) begin
        failures++; $display("FAIL stall_rd beat%0d cycle=%0d dat=%08h exp cycle=%0d dat=%08h",
                             i, b_ack_n[i], b_rd[i], ea[i], b_wd[i]);
      end
    end
    checks++;
    if (b_post !== 0) begin failures++; $display("FAIL stall_post_ack got=%0d exp=0", b_post); end
  endtask

  task automatic test_out_of_range();
    int lat; logic ga, ge; logic [31:0] dr;
    wb_single(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, lat, ga, ge, dr);
    wb_single(0, 1'b0, 32'h1000, 4'hF, 32'h0, lat, ga, ge, dr);
    checks++;
    if (ge !== 1'b1 || ga !== 1'b0 || lat !== 0) begin
      failures++; $display("FAIL oor_rd_resp err=%b ack=%b lat=%0d exp err=1 ack=0 lat=0", ge, ga, lat);
    end
    checks++;
    if (dr !== 32'h0) begin failures++; $display("FAIL oor_rd_dat got=%08h exp=0", dr); end
    wb_single(0, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, lat, ga, ge, dr);
    checks++;
    if (ge !== 1'b1 || ga !== 1'b0) begin
      failures++; $display("FAIL oor_wr_resp err=%b ack=%b exp err=1 ack=0", ge, ga);
    end
    wb_single(0, 1'b0, 32'h0, 4'hF, 32'h0, lat, ga, ge, dr);
    checks++;
    if (dr !== 32'hCAFE_F00D) begin failures++; $display("FAIL oor_wr_untouched got=%08h exp=cafef00d", dr); end
  endtask

  task automatic test_abort();
    int lat; logic ga, ge; logic [31:0] dr; int nresp;
    wb_single(3, 1'b1, 32'h30, 4'hF, 32'h5555_AAAA, lat, ga, ge, dr);
    checks++;
    if (lat !== 5 || ga !== 1'b1) begin failures++; $display("FAIL ws5_wr_lat lat=%0d ack=%b exp lat=5 ack=1", lat, ga); end
    nresp = 0;
    cyc[3] = 1'b1; stb[3] = 1'b1; wen[3] = 1'b1; sel[3] = 4'hF; adr[3] = 32'h30;
    wdat[3] = 32'h0BAD_0BAD; cti[3] = CTI_CLASSIC;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); @(negedge clk);
      if (ack[3] || err[3]) nresp++;
      if (n == 1) begin cyc[3] = 1'b0; stb[3] = 1'b0; wen[3] = 1'b0; end
    end
    checks++;
    if (nresp !== 0) begin failures++; $display("FAIL abort_no_resp got=%0d responses exp=0", nresp); end
    wb_single(3, 1'b0, 32'h30, 4'hF, 32'h0, lat, ga, ge, dr);
    checks++;
    if (dr !== 32'h5555_AAAA) begin failures++; $display("FAIL abort_ram_untouched got=%08h exp=5555aaaa", dr); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic ga, ge; logic [31:0] dr;
    cyc[3] = 1'b1; stb[3] = 1'b1; wen[3] = 1'b0; sel[3] = 4'hF; adr[3] = 32'h30; cti[3] = CTI_CLASSIC;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; wen[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h10; cti[0] = CTI_CLASSIC;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ack[0] !== 1'b1 || ack[3] !== 1'b0) begin
      failures++; $display("FAIL rst_pre ack0=%b ack3=%b exp 1 0", ack[0], ack[3]);
    end
    #1;
    reset_n = 1'b0;
    for (int d = 0; d < 4; d++) begin cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0; end
    #1;
    checks++;
    if (ack[0] !== 1'b0 || rdat[0] !== 32'h0) begin
      failures++; $display("FAIL rst_async_dut0 ack=%b dat=%08h exp 0 0", ack[0], rdat[0]);
    end
    checks++;
    if (ack[3] !== 1'b0 || err[3] !== 1'b0) begin
      failures++; $display("FAIL rst_async_dut3 ack=%b err=%b exp 0 0", ack[3], err[3]);
    end
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    wb_single(3, 1'b0, 32'h30, 4'hF, 32'h0, lat, ga, ge, dr);
    checks++;
    if (lat !== 5 || dr !== 32'h5555_AAAA) begin
      failures++; $display("FAIL rst_then_rd lat=%0d dat=%08h exp lat=5 dat=5555aaaa", lat, dr);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0; sel[d] = '0;
      adr[d] = '0; wdat[d] = '0; cti[d] = CTI_CLASSIC;
    end
    for (int i = 0; i < 8; i++) b_wd[i] = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    test_classic();
    test_wait_states();
    test_byte_lanes();
    test_burst_wrap();
    test_burst_stall();
    test_out_of_range();
    test_abort();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zap_wb_ram_responder.md
ZAP_WB_RAM_RESPONDER -- requirements
Module: zap_wb_ram_responder

Interface
REQ-001 Parameter DEPTH, default 1024, is the RAM size in 32-bit words and SHALL be a power of two, at least 4.
REQ-002 Parameter WAIT_STATES, default 0, is the number of extra cycles inserted before the first ack of each access (range 0-15).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of word 0 and SHALL be aligned to 4*DEPTH.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  clock; all flops SHALL use its rising edge.
REQ-006 i_reset_n  in  1  asynchronous active-low reset.
REQ-007 i_wb_cyc  in  1  bus cycle valid.
REQ-008 i_wb_stb  in  1  strobe; a request is present when i_wb_cyc and i_wb_stb are both high.
REQ-009 i_wb_wen  in  1  1 = write, 0 = read.
REQ-010 i_wb_sel  in  4  byte lane enables for writes.
REQ-011 i_wb_adr  in  32  byte address; bits [1:0] SHALL be ignored.
REQ-012 i_wb_dat  in  32  write data.
REQ-013 i_wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; other values SHALL be treated as 000.
REQ-014 o_wb_dat  out  32  read data, valid only while o_wb_ack is high.
REQ-015 o_wb_ack  out  1  registered acknowledge.
REQ-016 o_wb_err  out  1  registered error acknowledge.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 In IDLE, a sampled request SHALL latch the address word index and wen/sel/dat.
- If WAIT_STATES is 0, the FSM SHALL go to RESP.
- Otherwise it SHALL load the counter with WAIT_STATES-1 and go to WAIT.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-020 For a request first sampled at edge k, o_wb_ack or o_wb_err SHALL be high during the cycle following edge k+WAIT_STATES.
REQ-021 The response SHALL be exactly one cycle wide per beat.
REQ-022 o_wb_err SHALL replace o_wb_ack when the address lies outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
- An errored write SHALL NOT modify RAM.
- An errored read SHALL drive o_wb_dat to 0.
- o_wb_ack and o_wb_err SHALL never be high together.
REQ-023 A write SHALL commit only the byte lanes with i_wb_sel set, on the edge that asserts o_wb_ack.
REQ-024 A read SHALL return the full word regardless of i_wb_sel.
REQ-025 Classic cycle (cti=000): after the single response beat the FSM SHALL return to IDLE with ack low for at least one cycle, so a held stb is never acked twice.
REQ-026 Incrementing burst (cti=010 sampled while acking, with stb still high):
- The next beat SHALL be acked on the immediately following cycle with no wait states.
- The address SHALL be (previous word index + 1) mod DEPTH.
- The new beat's wen/sel/dat SHALL be sampled on that beat.
REQ-027 End of burst (cti=111): that beat SHALL be acked and the FSM SHALL return to IDLE.
REQ-028 If stb is low during a burst beat, the FSM SHALL hold in RESP with ack low until stb returns; the address SHALL NOT advance.
REQ-029 Abort: if i_wb_cyc falls in WAIT or RESP, the FSM SHALL go to IDLE at the next edge with no ack, no err and no RAM write.
REQ-030 A burst that begins in range and crosses the top of the range SHALL wrap to word 0 and SHALL NOT raise err.

Reset
REQ-031 On assertion of i_reset_n=0 the following SHALL clear immediately, asynchronously:
- state to IDLE;
- o_wb_ack, o_wb_err, o_wb_dat and the counter to 0.
REQ-032 RAM contents SHALL NOT be reset.
REQ-033 Reset during WAIT or RESP SHALL abandon the access without a write.
REQ-034 Deassertion of reset SHALL take effect synchronously on the next rising edge; the first request SHALL be sampled no earlier than that edge.

Structure
REQ-035 The CTI encodings (CTI_CLASSIC, CTI_INCR, CTI_EOB) and the FSM state enum SHALL live in the shared package zap_wb_pkg.
REQ-036 Storage SHALL be a sub-module zap_be_sp_ram: single-port, byte-enable write, synchronous read, DEPTH x 32.
REQ-037 zap_wb_ram_responder SHALL contain only the FSM, the counter, the address logic and the response flops.

Verification
REQ-038 WAIT_STATES=0: write 32'hDEAD_BEEF to 0x10 with sel=1111, then classic read 0x10 -> ack one cycle after each request edge; read data 32'hDEAD_BEEF.
REQ-039 WAIT_STATES=3: read 0x10 with stb held high -> ack exactly in cycle k+4, once; ack low in cycle k+5.
REQ-040 Byte lanes: write 32'h1122_3344 with sel=0101 over 32'hFFFF_FFFF -> read returns 32'hFF22_FF44.
REQ-041 Burst (WAIT_STATES=2, DEPTH=1024, BASE_ADDR=0): 4 beats from 0xFF8 (last beat cti=111) -> acks in cycles k+3..k+6; words read from word indices 1022, 1023, 0, 1; no err.
REQ-042 Out of range: read 4*DEPTH -> o_wb_err for one cycle, ack low, data 0; an errored write leaves RAM unchanged.
REQ-043 Abort and reset: WAIT_STATES=5 write, cyc dropped at k+2 -> no ack and RAM unchanged; i_reset_n pulsed low mid-WAIT -> ack/err 0 immediately and state IDLE.
